mem_arbiter: RTL and testbench

- Shares the single RAM port among the instruction- and data-cache request ports of NCPU cores.
- Sits between the per-core caches (datapath_cache / cache side) and the memory controller.
- Sequences one RAM transaction at a time through a small FSM.
- Arbitration order: data requests before instruction requests; round-robin fairness across cores.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/rr_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types used by the memory arbiter and its helpers.
package cpu_types_pkg;

    localparam int unsigned WORD_BITS = 32;

    typedef logic [WORD_BITS-1:0] word_t;

    // Memory controller status as seen by the arbiter.
    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    // Arbiter states; prefixed to stay distinct from the ramstate_t ACCESS literal.
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } source_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan offsets from the far end down so the smallest offset from ptr wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr) + i) % int'(N));
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port among the icache and dcache ports of NCPU cores.
// Data requests beat instruction requests; round-robin across cores.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned NCPU   = 2,
    parameter int unsigned WORD_W = 32
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [NCPU-1:0]              iREN,
    input  logic [NCPU-1:0][WORD_W-1:0]  iaddr,
    input  logic [NCPU-1:0]              dREN,
    input  logic [NCPU-1:0]              dWEN,
    input  logic [NCPU-1:0][WORD_W-1:0]  daddr,
    input  logic [NCPU-1:0][WORD_W-1:0]  dstore,
    output logic [NCPU-1:0]              iwait,
    output logic [NCPU-1:0]              dwait,
    output logic [NCPU-1:0][WORD_W-1:0]  iload,
    output logic [NCPU-1:0][WORD_W-1:0]  dload,
    output logic                         ramREN,
    output logic                         ramWEN,
    output logic [WORD_W-1:0]            ramaddr,
    output logic [WORD_W-1:0]            ramstore,
    input  logic [WORD_W-1:0]            ramload,
    input  ramstate_t                    ramstate
);

    localparam int unsigned IDX_W = (NCPU > 1) ? $clog2(NCPU) : 1;

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_core_q, grant_core_d;
    source_t          grant_src_q, grant_src_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             d_valid, i_valid;
    logic [IDX_W-1:0] d_idx, i_idx;

    rr_pick #(
        .N     (NCPU),
        .IDX_W (IDX_W)
    ) u_pick_d (
        .req   (dREN | dWEN),
        .ptr   (rr_ptr_q),
        .valid (d_valid),
        .idx   (d_idx)
    );

    rr_pick #(
        .N     (NCPU),
        .IDX_W (IDX_W)
    ) u_pick_i (
        .req   (iREN),
        .ptr   (rr_ptr_q),
        .valid (i_valid),
        .idx   (i_idx)
    );

    // State and grant registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ARB_IDLE;
            grant_core_q <= '0;
            grant_src_q  <= ICACHE;
            rr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_core_q <= grant_core_d;
            grant_src_q  <= grant_src_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    // Pick in IDLE; in ACCESS drive the RAM from the registered grant and release on completion.
    always_comb begin
        logic active;
        state_d      = state_q;
        grant_core_d = grant_core_q;
        grant_src_d  = grant_src_q;
        rr_ptr_d     = rr_ptr_q;
        iwait        = '1;
        dwait        = '1;
        iload        = '0;
        dload        = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        active       = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (d_valid) begin
                    state_d      = ARB_ACCESS;
                    grant_core_d = d_idx;
                    grant_src_d  = DCACHE;
                end else if (i_valid) begin
                    state_d      = ARB_ACCESS;
                    grant_core_d = i_idx;
                    grant_src_d  = ICACHE;
                end
            end

            ARB_ACCESS: begin
                if (grant_src_q == DCACHE) begin
                    active = dREN[grant_core_q] | dWEN[grant_core_q];
                end else begin
                    active = iREN[grant_core_q];
                end

                if (!active) begin
                    // Requester withdrew: abandon quietly, fairness pointer untouched.
                    state_d = ARB_IDLE;
                end else begin
                    if (grant_src_q == DCACHE) begin
                        ramaddr = daddr[grant_core_q];
                        if (dWEN[grant_core_q]) begin
                            ramWEN   = 1'b1;
                            ramstore = dstore[grant_core_q];
                        end else begin
                            ramREN = 1'b1;
                        end
                    end else begin
                        ramaddr = iaddr[grant_core_q];
                        ramREN  = 1'b1;
                    end

                    // ERROR, BUSY and FREE all just hold the strobes and retry.
                    if (ramstate == ACCESS) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = IDX_W'((int'(grant_core_q) + 1) % int'(NCPU));
                        if (grant_src_q == DCACHE) begin
                            dwait[grant_core_q] = 1'b0;
                            dload[grant_core_q] = ramload;
                        end else begin
                            iwait[grant_core_q] = 1'b0;
                            iload[grant_core_q] = ramload;
                        end
                    end
                end
            end

            default: state_d = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with two cores.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic             CLK;
    logic             nRST;
    logic [1:0]       iREN, dREN, dWEN;
    logic [1:0][31:0] iaddr, daddr, dstore;
    logic [1:0]       iwait, dwait;
    logic [1:0][31:0] iload, dload;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    ramstate_t        ramstate;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(
        .NCPU   (2),
        .WORD_W (32)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .dwait    (dwait),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        clear_inputs();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        clear_inputs();
        #7;
        n_cmp++; if (iwait !== 2'b11) begin n_err++; $display("FAIL reset.iwait: got %b want 11", iwait); end
        n_cmp++; if (dwait !== 2'b11) begin n_err++; $display("FAIL reset.dwait: got %b want 11", dwait); end
        n_cmp++; if ({ramREN, ramWEN} !== 2'b00) begin n_err++; $display("FAIL reset.strobes: got %b want 00", {ramREN, ramWEN}); end
        n_cmp++; if ({ramaddr, ramstore} !== 64'h0) begin n_err++; $display("FAIL reset.addr_store: got %h want 0", {ramaddr, ramstore}); end
        n_cmp++; if ({iload, dload} !== 128'h0) begin n_err++; $display("FAIL reset.loads: got %h want 0", {iload, dload}); end
        #1 nRST = 1'b1;
    endtask

    // Both cores write continuously; grants must alternate starting at core0.
    task automatic test_back_to_back();
        logic [31:0] exp_addr [3];
        logic [31:0] exp_store [3];
        logic [1:0]  exp_dw;
        exp_addr  = '{32'h100, 32'h200, 32'h100};
        exp_store = '{32'hAAAA, 32'h5555, 32'hAAAA};
        tick();
        dWEN = 2'b11;
        daddr[0] = 32'h100; daddr[1] = 32'h200;
        dstore[0] = 32'hAAAA; dstore[1] = 32'h5555;
        ramstate = ACCESS;
        #1;
        n_cmp++; if (ramWEN !== 1'b0) begin n_err++; $display("FAIL b2b.idle_wen: got %b want 0", ramWEN); end
        for (int k = 0; k < 3; k++) begin
            exp_dw = 2'b11 ^ (2'b01 << (k % 2));
            tick();
            n_cmp++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin n_err++; $display("FAIL b2b.wen%0d: got %b%b want 10", k, ramWEN, ramREN); end
            n_cmp++; if (ramaddr !== exp_addr[k]) begin n_err++; $display("FAIL b2b.addr%0d: got %h want %h", k, ramaddr, exp_addr[k]); end
            n_cmp++; if (ramstore !== exp_store[k]) begin n_err++; $display("FAIL b2b.store%0d: got %h want %h", k, ramstore, exp_store[k]); end
            n_cmp++; if (dwait !== exp_dw) begin n_err++; $display("FAIL b2b.dwait%0d: got %b want %b", k, dwait, exp_dw); end
            tick();
            n_cmp++; if (ramWEN !== 1'b0 || dwait !== 2'b11) begin n_err++; $display("FAIL b2b.gap%0d: got wen=%b dwait=%b want 0/11", k, ramWEN, dwait); end
        end
        clear_inputs();
    endtask

    task automatic test_single_iread();
        tick();
        iREN[0] = 1'b1; iaddr[0] = 32'h40;
        ramstate = ACCESS; ramload = 32'h8C010004;
        #1;
        n_cmp++; if (ramREN !== 1'b0 || iwait !== 2'b11) begin n_err++; $display("FAIL iread.t: got ren=%b iwait=%b want 0/11", ramREN, iwait); end
        tick();
        n_cmp++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin n_err++; $display("FAIL iread.drive: got ren=%b addr=%h want 1/40", ramREN, ramaddr); end
        n_cmp++; if (iwait !== 2'b10) begin n_err++; $display("FAIL iread.iwait: got %b want 10", iwait); end
        n_cmp++; if (iload[0] !== 32'h8C010004 || iload[1] !== 32'h0) begin n_err++; $display("FAIL iread.iload: got %h want 000000008c010004", iload); end
        tick();
        n_cmp++; if (ramREN !== 1'b0 || iwait !== 2'b11) begin n_err++; $display("FAIL iread.idle: got ren=%b iwait=%b want 0/11", ramREN, iwait); end
        clear_inputs();
    endtask

    task automatic test_priority();
        tick();
        iREN[0] = 1'b1; iaddr[0] = 32'h80;
        dREN[1] = 1'b1; daddr[1] = 32'h300;
        ramstate = ACCESS; ramload = 32'h1234;
        tick();
        n_cmp++; if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin n_err++; $display("FAIL prio.data_first: got ren=%b addr=%h want 1/300", ramREN, ramaddr); end
        n_cmp++; if (dwait !== 2'b01 || iwait !== 2'b11) begin n_err++; $display("FAIL prio.waits: got d=%b i=%b want 01/11", dwait, iwait); end
        n_cmp++; if (dload[1] !== 32'h1234) begin n_err++; $display("FAIL prio.dload: got %h want 1234", dload[1]); end
        tick();
        dREN[1] = 1'b0;
        #1;
        n_cmp++; if (ramREN !== 1'b0 || iwait !== 2'b11) begin n_err++; $display("FAIL prio.gap: got ren=%b iwait=%b want 0/11", ramREN, iwait); end
        tick();
        n_cmp++; if (ramREN !== 1'b1 || ramaddr !== 32'h80 || iwait !== 2'b10) begin n_err++; $display("FAIL prio.instr: got ren=%b addr=%h iwait=%b want 1/80/10", ramREN, ramaddr, iwait); end
        tick();
        clear_inputs();
    endtask

    // RAM stalls with BUSY, ERROR, FREE before completing.
    task automatic test_busy();
        ramstate_t seq [4];
        logic [1:0] exp_dw;
        seq = '{BUSY, ERROR, FREE, ACCESS};
        tick();
        dREN[0] = 1'b1; daddr[0] = 32'h500;
        ramstate = BUSY; ramload = 32'hCAFE0001;
        #1;
        n_cmp++; if (ramREN !== 1'b0) begin n_err++; $display("FAIL busy.idle: got %b want 0", ramREN); end
        for (int k = 0; k < 4; k++) begin
            tick();
            ramstate = seq[k];
            #1;
            exp_dw = (k == 3) ? 2'b10 : 2'b11;
            n_cmp++; if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin n_err++; $display("FAIL busy.hold%0d: got ren=%b addr=%h want 1/500", k, ramREN, ramaddr); end
            n_cmp++; if (dwait !== exp_dw) begin n_err++; $display("FAIL busy.dwait%0d: got %b want %b", k, dwait, exp_dw); end
        end
        n_cmp++; if (dload[0] !== 32'hCAFE0001) begin n_err++; $display("FAIL busy.dload: got %h want cafe0001", dload[0]); end
        tick();
        n_cmp++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin n_err++; $display("FAIL busy.after: got ren=%b dwait=%b want 0/11", ramREN, dwait); end
        clear_inputs();
    endtask

    task automatic test_drop();
        do_reset();
        tick();
        dREN[0] = 1'b1; daddr[0] = 32'h600; ramstate = BUSY;
        tick();
        n_cmp++; if (ramREN !== 1'b1 || ramaddr !== 32'h600) begin n_err++; $display("FAIL drop.grant: got ren=%b addr=%h want 1/600", ramREN, ramaddr); end
        tick();
        dREN[0] = 1'b0; ramstate = ACCESS;
        #1;
        n_cmp++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin n_err++; $display("FAIL drop.release: got ren=%b dwait=%b want 0/11", ramREN, dwait); end
        tick();
        dREN = 2'b11; daddr[1] = 32'h700;
        #1;
        n_cmp++; if (ramREN !== 1'b0) begin n_err++; $display("FAIL drop.idle: got %b want 0", ramREN); end
        tick();
        n_cmp++; if (ramaddr !== 32'h600 || dwait !== 2'b10) begin n_err++; $display("FAIL drop.rr: got addr=%h dwait=%b want 600/10", ramaddr, dwait); end
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (ramREN !== 1'b0) begin n_err++; $display("FAIL drop.end: got %b want 0", ramREN); end
    endtask

    task automatic test_reset_mid();
        tick();
        dWEN[1] = 1'b1; daddr[1] = 32'h800; dstore[1] = 32'hDEAD; ramstate = BUSY;
        tick();
        n_cmp++; if (ramWEN !== 1'b1 || ramaddr !== 32'h800) begin n_err++; $display("FAIL rstmid.wen: got wen=%b addr=%h want 1/800", ramWEN, ramaddr); end
        #1 nRST = 1'b0;
        #1;
        n_cmp++; if (ramWEN !== 1'b0 || ramstore !== 32'h0) begin n_err++; $display("FAIL rstmid.drop: got wen=%b store=%h want 0/0", ramWEN, ramstore); end
        dWEN = 2'b11; daddr[0] = 32'h900; dstore[0] = 32'h77;
        #1 nRST = 1'b1;
        #1;
        n_cmp++; if (dwait !== 2'b11 || iwait !== 2'b11 || ramWEN !== 1'b0) begin n_err++; $display("FAIL rstmid.waits: got d=%b i=%b wen=%b want 11/11/0", dwait, iwait, ramWEN); end
        tick();
        n_cmp++; if (ramWEN !== 1'b1 || ramaddr !== 32'h900 || ramstore !== 32'h77) begin n_err++; $display("FAIL rstmid.first: got wen=%b addr=%h store=%h want 1/900/77", ramWEN, ramaddr, ramstore); end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single_iread();
        test_priority();
        test_busy();
        test_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
